// File: rtl/cam_reduce_tree_pipe.sv
// Pipelined AND/OR reduction tree for CAM match lines. Per-beat mode and mask
// travel with the data; one global stall freezes every stage together.

module cam_reduce_stage #(
    parameter int IW = 4,
    parameter int NL = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 advance,
    input  logic                 vld_d,
    input  logic                 op_d,
    input  logic [IW-1:0]        d,
    output logic                 vld_q,
    output logic                 op_q,
    output logic [(IW>>NL)-1:0]  q
);
    localparam int OW = IW >> NL;

    logic [IW-1:0] t;

    // In-place pairing: node j of a level only reads nodes 2j and 2j+1,
    // which have not been overwritten yet within that level.
    always_comb begin
        t = d;
        for (int lv = 1; lv <= NL; lv++) begin
            for (int j = 0; j < (IW >> lv); j++) begin
                t[j] = op_d ? (t[2*j] | t[2*j+1]) : (t[2*j] & t[2*j+1]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            op_q  <= 1'b0;
            q     <= '0;
        end else if (advance) begin
            vld_q <= vld_d;
            op_q  <= op_d;
            q     <= t[OW-1:0];
        end
    end
endmodule

module cam_reduce_tree_pipe #(
    parameter int WIDTH            = 128,
    parameter int LEVELS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_mask,
    input  logic             in_op_or,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_match,
    output logic             out_op_or
);
    localparam int L = $clog2(WIDTH);
    localparam int S = (L + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
    localparam int P = 1 << L;

    logic         advance;
    logic [S:0]   vld_pipe;
    logic [S:0]   op_pipe;
    logic [P-1:0] leaf;

    assign advance     = out_ready | ~out_valid;
    assign in_ready    = advance;
    assign vld_pipe[0] = in_valid & advance;
    assign op_pipe[0]  = in_op_or;

    // Masked bits and pad bits take the identity of the selected operator.
    always_comb begin
        leaf = {P{~in_op_or}};
        for (int i = 0; i < WIDTH; i++) begin
            leaf[i] = in_mask[i] ? in_data[i] : ~in_op_or;
        end
    end

    for (genvar s = 0; s < S; s++) begin : g_stg
        localparam int LO = s * LEVELS_PER_STAGE;
        localparam int NL = ((L - LO) < LEVELS_PER_STAGE) ? (L - LO) : LEVELS_PER_STAGE;
        localparam int IW = P >> LO;

        logic [IW-1:0]       d;
        logic [(IW>>NL)-1:0] q;

        if (s == 0) begin : g_leaf
            assign d = leaf;
        end else begin : g_chain
            assign d = g_stg[s-1].q;
        end

        cam_reduce_stage #(.IW(IW), .NL(NL)) u_stg (
            .clk     (clk),
            .rst_n   (rst_n),
            .advance (advance),
            .vld_d   (vld_pipe[s]),
            .op_d    (op_pipe[s]),
            .d       (d),
            .vld_q   (vld_pipe[s+1]),
            .op_q    (op_pipe[s+1]),
            .q       (q)
        );
    end

    assign out_valid = vld_pipe[S];
    assign out_op_or = op_pipe[S];
    assign out_match = g_stg[S-1].q[0];
endmodule

// File: tb/tb_cam_reduce_tree_pipe.sv
// Directed bench for cam_reduce_tree_pipe: default build plus WIDTH=100/LPS=3,
// checked through per-instance scoreboards against a bit-serial reference.

module tb_cam_reduce_tree_pipe;
    typedef struct packed { logic m; logic op; } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_op_or, out_valid, out_ready, out_match, out_op_or;
    logic [127:0] in_data, in_mask;
    logic         b_in_valid, b_in_ready, b_in_op_or, b_out_valid, b_out_ready, b_out_match, b_out_op_or;
    logic [99:0]  b_in_data, b_in_mask;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [15:0] vhist = '0;

    always #5 clk = ~clk;

    cam_reduce_tree_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mask(in_mask), .in_op_or(in_op_or),
        .out_valid(out_valid), .out_ready(out_ready), .out_match(out_match), .out_op_or(out_op_or)
    );

    cam_reduce_tree_pipe #(.WIDTH(100), .LEVELS_PER_STAGE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_mask(b_in_mask), .in_op_or(b_in_op_or),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_match(b_out_match), .out_op_or(b_out_op_or)
    );

    function automatic logic ref_red(input logic [127:0] d, input logic [127:0] m, input logic op, input int w);
        logic r;
        r = ~op;
        for (int i = 0; i < w; i++) begin
            if (m[i]) r = op ? (r | d[i]) : (r & d[i]);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [127:0] d, input logic [127:0] m, input logic op);
        logic acc;
        in_valid = 1'b1; in_data = d; in_mask = m; in_op_or = op;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        if (acc) qa.push_back('{m: ref_red(d, m, op, 128), op: op});
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [99:0] d, input logic [99:0] m, input logic op);
        logic acc;
        b_in_valid = 1'b1; b_in_data = d; b_in_mask = m; b_in_op_or = op;
        @(negedge clk);
        acc = b_in_ready;
        @(posedge clk);
        if (acc) qb.push_back('{m: ref_red({28'h0, d}, {28'h0, m}, op, 100), op: op});
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic wait_drain_a();
        for (int i = 0; i < 60 && qa.size() != 0; i++) @(negedge clk);
        check("drain_a", qa.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain_b();
        for (int i = 0; i < 60 && qb.size() != 0; i++) @(negedge clk);
        check("drain_b", qb.size(), 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        vhist = {vhist[14:0], out_valid};
        if (rst_n && out_valid && out_ready) begin
            if (qa.size() == 0) check("unexp_a", out_valid, 0);
            else begin
                ea = qa.pop_front();
                check("match_a", out_match, ea.m);
                check("op_a", out_op_or, ea.op);
            end
        end
        if (rst_n && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) check("unexp_b", b_out_valid, 0);
            else begin
                eb = qb.pop_front();
                check("match_b", b_out_match, eb.m);
                check("op_b", b_out_op_or, eb.op);
            end
        end
    end

    initial begin
        logic [127:0] d, m, ones;
        logic [99:0]  bd;
        logic         op, seen;
        int           k;
        ones = '1;
        rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; in_op_or = 1'b0;
        b_out_ready = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_in_mask = '0; b_in_op_or = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_match", out_match, 0);
        check("rst_op", out_op_or, 0);
        check("rst_ready", in_ready, 1);
        check("rst_valid_b", b_out_valid, 0);
        rst_n = 1'b1;

        // all-ones AND, latency, then one cleared bit
        send_a(ones, ones, 1'b0);
        k = 0;
        do begin @(negedge clk); k++; end while (!out_valid && k < 20);
        check("lat_a", k, 4);
        wait_drain_a();
        d = ones; d[77] = 1'b0;
        send_a(d, ones, 1'b0);
        wait_drain_a();

        // OR single bit, masked-out bit, fully masked in both modes
        d = '0; d[127] = 1'b1;
        send_a(d, ones, 1'b1);
        m = ones; m[127] = 1'b0;
        send_a(d, m, 1'b1);
        send_a('0, '0, 1'b0);
        send_a(ones, '0, 1'b1);
        wait_drain_a();

        // back-to-back alternating stream
        for (int i = 0; i < 8; i++) begin
            op = i[0];
            d = op ? '0 : ones;
            if ($urandom_range(0, 1) == 1) d[$urandom_range(0, 127)] = ~op;
            m = {$urandom, $urandom, $urandom, $urandom};
            send_a(d, m, op);
        end
        repeat (4) @(negedge clk);
        #1;
        check("no_bubble", vhist[8:0], 9'h0FF);
        wait_drain_a();

        // global stall with the pipe full
        out_ready = 1'b0;
        send_a(ones, ones, 1'b0);
        send_a('0, ones, 1'b1);
        d = ones; d[5] = 1'b0;
        send_a(d, ones, 1'b0);
        d = '0; d[0] = 1'b1;
        send_a(d, ones, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_ready", in_ready, 0);
            check("stall_valid", out_valid, 1);
            check("stall_match", out_match, 1);
            check("stall_op", out_op_or, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain_a();

        // WIDTH=100, LEVELS_PER_STAGE=3
        send_b('1, '1, 1'b0);
        k = 0;
        do begin @(negedge clk); k++; end while (!b_out_valid && k < 20);
        check("lat_b", k, 3);
        wait_drain_b();
        send_b('0, '1, 1'b1);
        bd = '1; bd[99] = 1'b0;
        send_b(bd, '1, 1'b0);
        bd = '0; bd[99] = 1'b1;
        send_b(bd, '1, 1'b1);
        wait_drain_b();

        // reset with beats in flight
        out_ready = 1'b0;
        send_a(ones, ones, 1'b0);
        send_a(ones, ones, 1'b0);
        send_a('0, ones, 1'b1);
        @(posedge clk); #1;
        check("pre_rst_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_ready", in_ready, 1);
        qa.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (8) begin @(negedge clk); seen |= out_valid; end
        check("no_stale", seen, 0);
        @(posedge clk); #1;
        d = ones; d[3] = 1'b0;
        send_a(d, ones, 1'b0);
        wait_drain_a();

        check("qa_empty", qa.size(), 0);
        check("qb_empty", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
